// File: rtl/signal_player_pkg.sv
// Shared definitions for the sampler test design: playback FSM encoding
// and the default sizing constants.
package signal_player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PLAY  = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DIV_WIDTH  = 16;

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample buffer: one write port, one synchronous read port
// with one cycle of latency. No reset, so contents survive rst_n.
module sample_ram
  import signal_player_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port and enabled read; rd_data holds between reads.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/signal_player.sv
// Pattern generator: replays buffered samples onto output pins at a
// programmable rate, once or looping, with registered outputs.
module signal_player
  import signal_player_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DIV_WIDTH  = DEF_DIV_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  input  logic [DIV_WIDTH-1:0]  divider,
  input  logic                  loop,
  input  logic                  start,
  input  logic                  stop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  sample_strobe,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DIV_WIDTH-1:0]  DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] last_r;
  logic [DIV_WIDTH-1:0]  div_r;
  logic                  loop_r;
  logic [DIV_WIDTH-1:0]  hold_r;
  logic [ADDR_WIDTH-1:0] rd_addr_r;
  logic [ADDR_WIDTH-1:0] rd_addr_nx;
  logic                  last_loaded_r;
  logic                  load;
  logic                  finish;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;

  sample_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_en  (rd_en),
    .rd_addr(rd_addr_r),
    .rd_data(rd_data)
  );

  // Address wrap, end-of-hold decisions and read enable. The read address
  // always runs one sample ahead of data_out, so a read is issued on every load.
  always_comb begin
    rd_addr_nx = '0;
    finish     = 1'b0;
    load       = 1'b0;
    if (rd_addr_r == last_r) begin
      rd_addr_nx = '0;
    end else begin
      rd_addr_nx = rd_addr_r + ADDR_ONE;
    end
    if ((state_r == ST_PLAY) && !stop && (hold_r == '0)) begin
      finish = last_loaded_r && !loop_r;
      load   = !(last_loaded_r && !loop_r);
    end else begin
      finish = 1'b0;
      load   = 1'b0;
    end
    rd_en = ((state_r == ST_FETCH) && !stop) || load;
  end

  // Playback FSM with hold counter, prefetch address and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      last_r        <= '0;
      div_r         <= '0;
      loop_r        <= 1'b0;
      hold_r        <= '0;
      rd_addr_r     <= '0;
      last_loaded_r <= 1'b0;
      data_out      <= '0;
      sample_strobe <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      sample_strobe <= 1'b0;
      done          <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start && !stop) begin
            last_r    <= last_addr;
            div_r     <= divider;
            loop_r    <= loop;
            rd_addr_r <= '0;
            busy      <= 1'b1;
            state_r   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (stop) begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            rd_addr_r     <= rd_addr_nx;
            hold_r        <= '0;
            last_loaded_r <= 1'b0;
            state_r       <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (stop) begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else if (hold_r != '0) begin
            hold_r <= hold_r - DIV_ONE;
          end else if (finish) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            data_out      <= rd_data;
            sample_strobe <= 1'b1;
            hold_r        <= div_r;
            rd_addr_r     <= rd_addr_nx;
            // Prefetch address wrapped to 0 means the sample just loaded is last_r.
            last_loaded_r <= (rd_addr_r == '0);
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/signal_player.md
# signal_player

Pattern generator, the output-side counterpart of the sampler input synchronizer: drives a buffered sequence of DATA_WIDTH-bit samples onto output pins at a programmable rate. Host logic preloads samples through a write port. A start pulse plays entries 0..last_addr once, or continuously in loop mode, with registered, glitch-free outputs. It sits between the host register/memory interface and the board output pins of the sampler test design.

## Interface
- DATA_WIDTH, 8, width of one sample / output pin group
- ADDR_WIDTH, 10, sample buffer address width (2^ADDR_WIDTH entries)
- DIV_WIDTH, 16, width of rate divider
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  write strobe into sample buffer
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- last_addr  in  ADDR_WIDTH  index of final sample to play; latched at start
- divider  in  DIV_WIDTH  each sample held divider+1 cycles; latched at start
- loop  in  1  1 = wrap from last_addr to 0 indefinitely; latched at start
- start  in  1  begin playback; honoured only when busy=0
- stop  in  1  abort playback
- data_out  out  DATA_WIDTH  registered sample output
- sample_strobe  out  1  one-cycle pulse on every cycle data_out takes a new sample
- busy  out  1  playback in progress
- done  out  1  one-cycle pulse on natural completion (non-loop only)

## Operation
- Reset values: data_out=0, sample_strobe=0, busy=0, done=0, FSM=IDLE. The buffer has no reset, so contents survive rst_n and are undefined after power-up.
- FSM states: IDLE, FETCH, PLAY.
- IDLE: start=1 and stop=0 → latch last_addr/divider/loop, issue read of address 0, go to FETCH. stop=1 in the same cycle as start → start ignored.
- FETCH: one cycle for synchronous buffer read latency → PLAY.
- PLAY: hold counter runs divider..0. When it reaches 0, load the prefetched next sample. The next address is always prefetched one sample ahead, so divider=0 gives one sample per clock with no gaps.
- End of sequence, loop=0: after sample last_addr has been held divider+1 cycles → IDLE, done pulse, data_out keeps last sample.
- End of sequence, loop=1: sample 0 follows last_addr with no extra cycle. Address wraps mod last_addr+1, never mod 2^ADDR_WIDTH.
- stop in FETCH/PLAY → IDLE at next edge, busy=0, no done, data_out holds current value.
- start while busy=1 → ignored. Input changes to last_addr/divider/loop while busy → no effect.
- Writes are accepted in any state. A write to an address not yet prefetched is played. A write to the currently prefetched address is not guaranteed to be played in this pass.
- last_addr=0 → single-sample sequence. In loop mode this is a constant output with a strobe every divider+1 cycles.
- rst_n asserted mid-playback → immediate return to reset values.

## Timing
- E0 = edge sampling start=1 in IDLE. Then:
  - busy=1 from E0+1.
  - data_out=buf[0] and sample_strobe=1 at E0+2.
  - Sample k appears at E0+2+k·(divider+1).
- Non-loop completion at edge E0+2+(last_addr+1)·(divider+1): busy=0 and done=1 for one cycle.
- Total busy duration = 2+(last_addr+1)·(divider+1) cycles.
- A new start is accepted in the same cycle done is high.
- Write-to-output latency for a freshly written entry: at least 2 cycles before its scheduled prefetch.

## Structure
- Shared package: FSM state encoding (IDLE, FETCH, PLAY) and the default parameter constants for the sampler design.
- Sub-module sample_ram:
  - simple dual-port memory
  - 2^ADDR_WIDTH × DATA_WIDTH
  - one write port, one synchronous-read port, 1-cycle read latency
  - no reset
- The FSM, hold counter and address counter stay in signal_player.

## Test plan
- Write buf[0..3]=0x11,0x22,0x33,0x44; last_addr=3, divider=0, loop=0; start → data_out 0x11,0x22,0x33,0x44 on consecutive cycles from E0+2; strobe high 4 cycles; done at E0+6; data_out stays 0x44.
- Same data, divider=2 → each value held 3 cycles, strobes at E0+2/5/8/11, done at E0+14.
- loop=1, last_addr=1, buf[0..1]=0xA5,0x5A, divider=0 → alternating 0xA5/0x5A every cycle for 20 cycles, no gap at wrap; stop → busy=0 next edge, no done, output held.
- start and stop together in IDLE → busy stays 0. start while busy (mid-sequence) → timing unchanged.
- rst_n low at E0+5 of a 16-sample run → data_out=0, busy=0 immediately. After release, restart replays the preserved buffer contents.
- During loop playback, rewrite buf[3]=0xFF while address 0 is playing (last_addr=7) → 0xFF appears in the same pass. last_addr=0, loop=0 → one sample, done at E0+3 for divider=0.
